// File: rtl/div_recon_mult.sv
// rtl/div_recon_mult.sv - radix-2 shift-add rebuild of dividend = quotient * divisor + remainder
module div_recon_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     quotient,
  input  logic [WIDTH-1:0]     divisor,
  input  logic [WIDTH-1:0]     remainder,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   dividend,
  output logic                 rem_err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic               err_q;
  logic [2*WIDTH-1:0] acc_next;

  // The remainder seeds the accumulator, so the addend costs no extra cycle.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      mplier   <= '0;
      mcand    <= '0;
      acc      <= '0;
      count    <= '0;
      err_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dividend <= '0;
      rem_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mplier <= quotient;
            mcand  <= {{WIDTH{1'b0}}, divisor};
            acc    <= {{WIDTH{1'b0}}, remainder};
            count  <= '0;
            err_q  <= (divisor == '0) || (remainder >= divisor);
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            dividend <= acc_next;
            rem_err  <= err_q;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_recon_mult.sv
// tb/tb_div_recon_mult.sv - self-checking bench for div_recon_mult against an arithmetic model
module tb_div_recon_mult;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   quotient;
  logic [W-1:0]   divisor;
  logic [W-1:0]   remainder;
  logic           busy;
  logic           done;
  logic [2*W-1:0] dividend;
  logic           rem_err;

  int tests = 0;
  int fails = 0;

  div_recon_mult #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .quotient(quotient), .divisor(divisor), .remainder(remainder),
    .busy(busy), .done(done), .dividend(dividend), .rem_err(rem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One single-cycle start pulse; operands are scrambled right after acceptance.
  task automatic do_op(input logic [W-1:0] q, input logic [W-1:0] d, input logic [W-1:0] r,
                       input string tag);
    int exp_val, exp_err, nb, dcyc, overlap;
    bit got;
    exp_val = int'(q) * int'(d) + int'(r);
    exp_err = (d == 0 || r >= d) ? 1 : 0;
    @(negedge clk);
    start = 1'b1; quotient = q; divisor = d; remainder = r;
    @(posedge clk);
    #1;
    start = 1'b0;
    quotient = W'($urandom); divisor = W'($urandom); remainder = W'($urandom);
    nb = 0; dcyc = 0; overlap = 0; got = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (busy && done) overlap++;
      if (done) begin got = 1; dcyc = i; end
    end
    chk({tag, " done_seen"}, 32'(got), 1);
    chk({tag, " done_latency"}, 32'(dcyc), W + 1);
    chk({tag, " busy_cycles"}, 32'(nb), W);
    chk({tag, " busy_done_overlap"}, 32'(overlap), 0);
    chk({tag, " dividend"}, 32'(dividend), 32'(exp_val));
    chk({tag, " rem_err"}, 32'(rem_err), 32'(exp_err));
    @(negedge clk);
    chk({tag, " done_single"}, 32'(done), 0);
    chk({tag, " dividend_held"}, 32'(dividend), 32'(exp_val));
  endtask

  initial begin
    int nd, last, gapbad, valbad, seen;
    rst = 1'b0; start = 1'b0; quotient = '0; divisor = '0; remainder = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset dividend", 32'(dividend), 0);
    chk("reset rem_err", 32'(rem_err), 0);

    rst = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || done || dividend != 0) seen++;
    end
    chk("idle_after_reset", 32'(seen), 0);

    do_op(8'd13, 8'd7, 8'd5, "basic");
    do_op(8'd255, 8'd255, 8'd254, "max");
    do_op(8'd20, 8'd0, 8'd3, "div_zero");
    do_op(8'd4, 8'd7, 8'd9, "rem_big");

    // start held high: results every W+2 cycles with fixed operands
    @(negedge clk);
    start = 1'b1; quotient = 8'd2; divisor = 8'd3; remainder = 8'd1;
    nd = 0; last = 0; gapbad = 0; valbad = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        if (dividend != 16'd7) valbad++;
        if (nd > 0 && i - last != W + 2) gapbad++;
        nd++; last = i;
      end
    end
    start = 1'b0;
    chk("b2b done_count", 32'(nd), 3);
    chk("b2b gap", 32'(gapbad), 0);
    chk("b2b value", 32'(valbad), 0);
    repeat (W + 4) @(negedge clk);

    // reset during the 4th RUN cycle
    @(negedge clk);
    start = 1'b1; quotient = 8'd9; divisor = 8'd9; remainder = 8'd1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    chk("abort dividend", 32'(dividend), 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    chk("abort no_activity", 32'(seen), 0);
    do_op(8'd6, 8'd6, 8'd0, "after_abort");

    // a single pulse is accepted once only
    seen = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    chk("single_accept", 32'(seen), 0);

    for (int k = 0; k < 12; k++) begin
      do_op(W'($urandom), W'($urandom), W'($urandom), $sformatf("rand%0d", k));
    end
    do_op(8'd0, 8'd0, 8'd0, "all_zero");
    do_op(8'd0, 8'd200, 8'd0, "q_zero");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/div_recon_mult.md
# div_recon_mult

Sequential shift-add multiplier that rebuilds a dividend from the quotient, divisor and remainder produced by the team's divider: dividend = quotient × divisor + remainder. It sits beside the divider as the inverse datapath. It is used in-system to cross-check division results and in the bench as a golden reconstruction path. It is radix-2, one partial product per clock, with a start/busy/done handshake.

## Interface
- WIDTH, 8, operand width; the result is 2·WIDTH bits.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- quotient  input  WIDTH  multiplier operand; latched when start is accepted.
- divisor  input  WIDTH  multiplicand operand; latched when start is accepted.
- remainder  input  WIDTH  addend; latched when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when dividend is valid.
- dividend  output  2·WIDTH  reconstructed result; held until the next result.
- rem_err  output  1  high when the latched remainder ≥ divisor, or divisor == 0; updated with dividend.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- **IDLE**
  - On start=1 at edge E: latch the operands, acc ← zero-extended remainder, count ← 0, go to RUN.
  - Also compute and hold the error flag internally at E.
  - With start=0, stay in IDLE.
- **RUN**
  - Each edge: if the multiplier LSB is 1, acc ← acc + mcand.
  - Then mcand ← mcand << 1, multiplier ← multiplier >> 1, count ← count + 1.
  - After WIDTH iterations, go to DONE.
  - On that same edge, load dividend ← final acc and rem_err ← the latched flag.
- **DONE**
  - done=1 for exactly this one cycle, then go to IDLE unconditionally.
- start is ignored in RUN and DONE; it is not queued.
- start held high continuously gives back-to-back operations, one every WIDTH+2 cycles.
- Arithmetic:
  - acc and mcand are 2·WIDTH bits wide.
  - The result never overflows, because (2^W−1)² + (2^W−1) < 2^(2W).
  - This holds even when rem_err=1.
- dividend = 0 exactly when divisor == 0 or quotient == 0, and remainder == 0.
- Operand inputs may change freely after the accepting edge; they do not affect the result in flight.

## Timing
- Reset values (rst low, asynchronous):
  - state = IDLE.
  - busy = 0, done = 0, dividend = 0, rem_err = 0.
  - All internal registers = 0.
- Reset asserted mid-RUN or in DONE aborts the operation. No done pulse is generated, and the output is cleared to 0.
- The first start accepted is the first rising edge that samples start=1 while rst is high and the state is IDLE.
- Latency for start accepted at edge E:
  - busy=1 in the cycles after edges E … E+WIDTH−1.
  - dividend and rem_err update at edge E+WIDTH.
  - done=1 in the cycle after edge E+WIDTH.
  - IDLE is re-entered at edge E+WIDTH+1.
  - Total: WIDTH+1 cycles from acceptance to the done cycle.
- busy and done are never high together.
- dividend and rem_err change only at the edge entering DONE, or on reset.

## Test plan
- WIDTH=8, start with q=13, d=7, r=5 → dividend=96, rem_err=0. done is a single pulse 9 cycles after acceptance; busy is high for 8 cycles.
- q=255, d=255, r=254 → dividend=65279, rem_err=0. Confirms the maximum value with no overflow.
- q=20, d=0, r=3 → dividend=3, rem_err=1. Then q=4, d=7, r=9 → dividend=37, rem_err=1.
- start held high for 30 cycles with fixed operands q=2, d=3, r=1 → dividend=7 each time, with done pulses 10 cycles apart. Changing the operands during RUN does not alter the in-flight result.
- Reset pulsed low at the 4th RUN cycle → busy=0, done=0, dividend=0 immediately, with no done pulse. A new start with q=6, d=6, r=0 then gives dividend=36.
- Release from reset with start=0 → outputs stay 0 and no busy is seen. A single-cycle start pulse is accepted exactly once.
